// File: rtl/cmn_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmn_arb_pkg
// Brief    : Shared constants and mode names for the cmn priority arbiters.
// Revision : 1.0 - initial release
// ============================================================================
package cmn_arb_pkg;

  // Arbitration flavour, derived from STARVE_LIMIT (0 means pure fixed priority)
  typedef enum logic [0:0] {
    ARB_FIXED       = 1'b0,
    ARB_FIXED_PROMO = 1'b1
  } arb_mode_e;

  // Default number of lost arbitrations before a waiting channel is promoted
  localparam int C_STARVE_LIMIT_DEF = 8;

endpackage : cmn_arb_pkg
`default_nettype wire

// File: rtl/cmn_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : cmn_pipe_reg
// Brief    : Single-entry forward register with valid/ready. Accepts a new
//            beat whenever empty or being drained, giving 1 beat/cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cmn_pipe_reg #(
  parameter type PLD_TYPE = logic
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_vld,
  output logic    o_rdy,
  input  PLD_TYPE i_pld,
  output logic    o_vld,
  input  logic    i_rdy,
  output PLD_TYPE o_pld
);

  logic    r_full;
  PLD_TYPE r_pld;

  // Room for a new beat when empty or when the held beat leaves this cycle
  assign o_rdy = !r_full || i_rdy;
  assign o_vld = r_full;
  assign o_pld = r_pld;

  // Fill has priority over drain so simultaneous drain+fill keeps the entry full
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_pld  <= '0;
    end else if (i_vld && o_rdy) begin
      r_full <= 1'b1;
      r_pld  <= i_pld;
    end else if (i_rdy) begin
      r_full <= 1'b0;
    end
  end

endmodule : cmn_pipe_reg
`default_nettype wire

// File: rtl/cmn_prio_arb_n.sv
`default_nettype none
// ============================================================================
// Module   : cmn_prio_arb_n
// Brief    : N-channel fixed-priority valid/ready arbiter (index 0 highest)
//            with starvation promotion, grant lock for the combinational
//            output and an optional registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module cmn_prio_arb_n
  import cmn_arb_pkg::*;
#(
  parameter type PLD_TYPE     = logic,
  parameter int  N            = 4,
  parameter int  STARVE_LIMIT = C_STARVE_LIMIT_DEF,
  parameter int  OUT_REG      = 1,
  localparam int IDX_W        = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     s_vld,
  output logic [N-1:0]     s_rdy,
  input  PLD_TYPE          s_pld [N],
  output logic             m_vld,
  input  logic             m_rdy,
  output PLD_TYPE          m_pld,
  output logic [IDX_W-1:0] m_idx,
  output logic             m_promo
);

  localparam arb_mode_e c_mode     = (STARVE_LIMIT == 0) ? ARB_FIXED : ARB_FIXED_PROMO;
  localparam bit        c_promo_en = (c_mode == ARB_FIXED_PROMO);
  localparam bit        c_lock_en  = (OUT_REG == 0);
  localparam int        c_wc_w     = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [c_wc_w-1:0] wcnt_t;

  typedef struct packed {
    PLD_TYPE pld;
    idx_t    idx;
    logic    promo;
  } beat_t;

  localparam wcnt_t c_limit = c_wc_w'(STARVE_LIMIT);

  wcnt_t        r_wcnt [N];
  logic [N-1:0] w_starved;
  idx_t         w_sel;
  logic         w_promo;
  logic         w_any;
  logic         w_adv;
  logic         w_hs;
  logic         r_lock;
  idx_t         r_lock_idx;
  logic         r_lock_promo;

  assign w_any = |s_vld;
  assign w_hs  = w_any && w_adv;

  // A channel is starved once it has lost STARVE_LIMIT handshakes while waiting
  always_comb begin
    w_starved = '0;
    for (int i = 0; i < N; i++) begin
      w_starved[i] = c_promo_en && s_vld[i] && (r_wcnt[i] == c_limit);
    end
  end

  // Priority select: lock beats starvation beats plain fixed priority
  always_comb begin
    w_sel   = '0;
    w_promo = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (s_vld[i]) w_sel = idx_t'(i);
    end
    if (|w_starved) begin
      w_promo = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
        if (w_starved[i]) w_sel = idx_t'(i);
      end
    end
    if (r_lock) begin
      w_sel   = r_lock_idx;
      w_promo = r_lock_promo;
    end
  end

  // Only the selected channel may see ready, and only when the beat can move
  always_comb begin
    s_rdy = '0;
    if (w_hs) s_rdy[w_sel] = 1'b1;
  end

  // Wait counters: clear on own handshake or idle, count others' handshakes
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        r_wcnt[i] <= '0;
      end else if (!s_vld[i] || (w_hs && (w_sel == idx_t'(i)))) begin
        r_wcnt[i] <= '0;
      end else if (w_hs && (r_wcnt[i] != c_limit)) begin
        r_wcnt[i] <= r_wcnt[i] + wcnt_t'(1);
      end
    end
  end

  // Grant lock keeps the combinational output stable while the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock       <= 1'b0;
      r_lock_idx   <= '0;
      r_lock_promo <= 1'b0;
    end else if (c_lock_en && w_any) begin
      if (!m_rdy) begin
        r_lock       <= 1'b1;
        r_lock_idx   <= w_sel;
        r_lock_promo <= w_promo;
      end else begin
        r_lock       <= 1'b0;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic  w_pipe_rdy;
      beat_t w_beat_in;
      beat_t w_beat_out;

      assign w_beat_in = '{pld: s_pld[w_sel], idx: w_sel, promo: w_promo};
      assign w_adv     = w_pipe_rdy && !rst;

      cmn_pipe_reg #(
        .PLD_TYPE (beat_t)
      ) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_hs),
        .o_rdy (w_pipe_rdy),
        .i_pld (w_beat_in),
        .o_vld (m_vld),
        .i_rdy (m_rdy),
        .o_pld (w_beat_out)
      );

      assign m_pld   = w_beat_out.pld;
      assign m_idx   = w_beat_out.idx;
      assign m_promo = w_beat_out.promo;
    end else begin : g_out_comb
      assign w_adv   = m_rdy && !rst;
      assign m_vld   = w_any && !rst;
      assign m_pld   = s_pld[w_sel];
      assign m_idx   = w_sel;
      assign m_promo = w_promo;
    end
  endgenerate

endmodule : cmn_prio_arb_n
`default_nettype wire
